// File: rtl/traffic_phase_scheduler.sv
// Two-approach intersection phase sequencer: NS/EW ring with an optional all-red
// pedestrian WALK phase. A single countdown timer times every phase; programmed N = N+1 cycles.
module traffic_phase_scheduler #(
   parameter int unsigned TW         = 3,
   parameter int unsigned DEF_GREEN  = 5,
   parameter int unsigned DEF_YELLOW = 1,
   parameter int unsigned DEF_CLEAR  = 0,
   parameter int unsigned DEF_WALK   = 3
) (
   input  logic          clk_i,
   input  logic          reset_ni,
   input  logic          cfg_load_i,
   input  logic [TW-1:0] green_time_i,
   input  logic [TW-1:0] yellow_time_i,
   input  logic [TW-1:0] clear_time_i,
   input  logic [TW-1:0] walk_time_i,
   input  logic          ped_req_i,
   input  logic          hold_i,
   output logic          ns_green_o,
   output logic          ns_yellow_o,
   output logic          ns_red_o,
   output logic          ew_green_o,
   output logic          ew_yellow_o,
   output logic          ew_red_o,
   output logic          walk_o,
   output logic          ped_pending_o,
   output logic          ped_ack_o,
   output logic [2:0]    phase_o,
   output logic          phase_start_o
);

   typedef enum logic [2:0] {
      StNsGreen  = 3'd0,
      StNsYellow = 3'd1,
      StClearA   = 3'd2,
      StEwGreen  = 3'd3,
      StEwYellow = 3'd4,
      StClearB   = 3'd5,
      StWalk     = 3'd6,
      StIllegal  = 3'd7
   } phase_e;

   phase_e        phase_q, phase_d;
   phase_e        ring_next;
   logic [TW-1:0] timer_q, timer_d;
   logic [TW-1:0] next_dur;
   logic [TW-1:0] cfg_green_q, cfg_yellow_q, cfg_clear_q, cfg_walk_q;
   logic          ret_ew_q, ret_ew_d;
   logic          ped_pending_q, ped_pending_d;
   logic          ped_ack_q, ped_ack_d;
   logic          phase_start_q, phase_start_d;
   logic          advance;
   logic          enter_walk;

   // Successor of the current phase in the ring; WALK is spliced in after either clearance.
   always_comb begin
      ring_next = StClearA;
      case (phase_q)
         StNsGreen:  ring_next = StNsYellow;
         StNsYellow: ring_next = StClearA;
         StClearA:   ring_next = ped_pending_q ? StWalk : StEwGreen;
         StEwGreen:  ring_next = StEwYellow;
         StEwYellow: ring_next = StClearB;
         StClearB:   ring_next = ped_pending_q ? StWalk : StNsGreen;
         StWalk:     ring_next = ret_ew_q ? StEwGreen : StNsGreen;
         default:    ring_next = StClearA;
      endcase
   end

   // Duration loaded on entry to the successor; uses the config already in force, so a
   // cfg_load on the transition edge only takes effect from the following phase.
   always_comb begin
      next_dur = cfg_green_q;
      case (ring_next)
         StNsGreen, StEwGreen:   next_dur = cfg_green_q;
         StNsYellow, StEwYellow: next_dur = cfg_yellow_q;
         StClearA, StClearB:     next_dur = cfg_clear_q;
         StWalk:                 next_dur = cfg_walk_q;
         default:                next_dur = cfg_clear_q;
      endcase
   end

   // Timer / phase next-state; illegal encoding recovers to CLEAR_A regardless of hold.
   always_comb begin
      phase_d       = phase_q;
      timer_d       = timer_q;
      ret_ew_d      = ret_ew_q;
      advance       = 1'b0;
      enter_walk    = 1'b0;
      ped_pending_d = ped_pending_q;

      if (phase_q == StIllegal) begin
         advance = 1'b1;
      end else if (!hold_i) begin
         if (timer_q == '0) begin
            advance = 1'b1;
         end else begin
            timer_d = timer_q - TW'(1);
         end
      end

      if (advance) begin
         phase_d = ring_next;
         timer_d = next_dur;
         if (ring_next == StWalk) begin
            enter_walk = 1'b1;
            ret_ew_d   = (phase_q == StClearA);
         end
      end

      // Entering WALK serves the request, including one arriving on that same edge.
      if (enter_walk) begin
         ped_pending_d = 1'b0;
      end else if (ped_req_i && (phase_q != StWalk)) begin
         ped_pending_d = 1'b1;
      end

      ped_ack_d     = enter_walk;
      phase_start_d = advance;
   end

   // Phase, timer and pedestrian state registers.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         phase_q       <= StNsGreen;
         timer_q       <= TW'(DEF_GREEN);
         ret_ew_q      <= 1'b0;
         ped_pending_q <= 1'b0;
         ped_ack_q     <= 1'b0;
         phase_start_q <= 1'b1;
      end else begin
         phase_q       <= phase_d;
         timer_q       <= timer_d;
         ret_ew_q      <= ret_ew_d;
         ped_pending_q <= ped_pending_d;
         ped_ack_q     <= ped_ack_d;
         phase_start_q <= phase_start_d;
      end
   end

   // Active timing configuration; never touches the running timer.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cfg_green_q  <= TW'(DEF_GREEN);
         cfg_yellow_q <= TW'(DEF_YELLOW);
         cfg_clear_q  <= TW'(DEF_CLEAR);
         cfg_walk_q   <= TW'(DEF_WALK);
      end else if (cfg_load_i) begin
         cfg_green_q  <= green_time_i;
         cfg_yellow_q <= yellow_time_i;
         cfg_clear_q  <= clear_time_i;
         cfg_walk_q   <= walk_time_i;
      end
   end

   // Moore lamp decode; anything not explicitly green/yellow is red on both heads.
   always_comb begin
      ns_green_o  = 1'b0;
      ns_yellow_o = 1'b0;
      ns_red_o    = 1'b1;
      ew_green_o  = 1'b0;
      ew_yellow_o = 1'b0;
      ew_red_o    = 1'b1;
      walk_o      = 1'b0;
      case (phase_q)
         StNsGreen: begin
            ns_green_o = 1'b1;
            ns_red_o   = 1'b0;
         end
         StNsYellow: begin
            ns_yellow_o = 1'b1;
            ns_red_o    = 1'b0;
         end
         StEwGreen: begin
            ew_green_o = 1'b1;
            ew_red_o   = 1'b0;
         end
         StEwYellow: begin
            ew_yellow_o = 1'b1;
            ew_red_o    = 1'b0;
         end
         StWalk:  walk_o = 1'b1;
         default: ;
      endcase
   end

   assign phase_o       = phase_q;
   assign ped_pending_o = ped_pending_q;
   assign ped_ack_o     = ped_ack_q;
   assign phase_start_o = phase_start_q;

   // Conflicting greens must be impossible by construction.
   a_green_safe: assert property (@(posedge clk_i) disable iff (!reset_ni)
      !((ns_green_o && !ew_red_o) || (ew_green_o && !ns_red_o)));
   a_ns_onehot: assert property (@(posedge clk_i) disable iff (!reset_ni)
      $onehot({ns_green_o, ns_yellow_o, ns_red_o}));
   a_ew_onehot: assert property (@(posedge clk_i) disable iff (!reset_ni)
      $onehot({ew_green_o, ew_yellow_o, ew_red_o}));

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: directed scenarios plus random traffic,
// all compared cycle by cycle against a phase-length reference model.
module tb_traffic_phase_scheduler;

   localparam int TW = 3;

   logic          clk_i = 1'b0;
   logic          reset_ni = 1'b0;
   logic          cfg_load_i = 1'b0;
   logic [TW-1:0] green_time_i = '0;
   logic [TW-1:0] yellow_time_i = '0;
   logic [TW-1:0] clear_time_i = '0;
   logic [TW-1:0] walk_time_i = '0;
   logic          ped_req_i = 1'b0;
   logic          hold_i = 1'b0;
   logic          ns_green_o, ns_yellow_o, ns_red_o;
   logic          ew_green_o, ew_yellow_o, ew_red_o;
   logic          walk_o, ped_pending_o, ped_ack_o, phase_start_o;
   logic [2:0]    phase_o;
   logic [12:0]   obs;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model: phase number, cycles spent so far, and length of the current phase.
   int m_phase, m_elapsed, m_dur;
   int cfg_g, cfg_y, cfg_c, cfg_w;
   bit m_pending, m_ret, m_ack, m_start;

   traffic_phase_scheduler dut (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .cfg_load_i   (cfg_load_i),
      .green_time_i (green_time_i),
      .yellow_time_i(yellow_time_i),
      .clear_time_i (clear_time_i),
      .walk_time_i  (walk_time_i),
      .ped_req_i    (ped_req_i),
      .hold_i       (hold_i),
      .ns_green_o   (ns_green_o),
      .ns_yellow_o  (ns_yellow_o),
      .ns_red_o     (ns_red_o),
      .ew_green_o   (ew_green_o),
      .ew_yellow_o  (ew_yellow_o),
      .ew_red_o     (ew_red_o),
      .walk_o       (walk_o),
      .ped_pending_o(ped_pending_o),
      .ped_ack_o    (ped_ack_o),
      .phase_o      (phase_o),
      .phase_start_o(phase_start_o)
   );

   always #5 clk_i = ~clk_i;

   assign obs = {phase_o, ns_green_o, ns_yellow_o, ns_red_o, ew_green_o, ew_yellow_o, ew_red_o,
                 walk_o, ped_pending_o, ped_ack_o, phase_start_o};

   function automatic logic [12:0] exp_vec();
      int p;
      p = m_phase;
      return {3'(p), p == 0, p == 1, !(p == 0 || p == 1), p == 3, p == 4, !(p == 3 || p == 4),
              p == 6, m_pending, m_ack, m_start};
   endfunction

   function automatic int dur_of(int p);
      case (p)
         0, 3:    return cfg_g + 1;
         1, 4:    return cfg_y + 1;
         2, 5:    return cfg_c + 1;
         default: return cfg_w + 1;
      endcase
   endfunction

   function automatic int next_of(int p);
      case (p)
         0:       return 1;
         1:       return 2;
         2:       return m_pending ? 6 : 3;
         3:       return 4;
         4:       return 5;
         5:       return m_pending ? 6 : 0;
         6:       return m_ret ? 3 : 0;
         default: return 2;
      endcase
   endfunction

   function automatic void model_reset();
      cfg_g = 5; cfg_y = 1; cfg_c = 0; cfg_w = 3;
      m_phase = 0; m_elapsed = 0; m_dur = 6;
      m_pending = 0; m_ret = 0; m_ack = 0; m_start = 1;
   endfunction

   function automatic void model_edge(bit req, bit hld, bit load, int g, int y, int c, int w);
      int prev;
      int nxt;
      bit entering;
      prev = m_phase;
      entering = 0;
      m_ack = 0;
      m_start = 0;
      if (!hld) begin
         m_elapsed++;
         if (m_elapsed >= m_dur) begin
            nxt = next_of(prev);
            if (nxt == 6) begin
               entering = 1;
               m_ret = (prev == 2);
            end
            m_phase = nxt;
            m_dur = dur_of(nxt);
            m_elapsed = 0;
            m_start = 1;
            m_ack = entering;
         end
      end
      if (entering) m_pending = 0;
      else if (req && prev != 6) m_pending = 1;
      if (load) begin
         cfg_g = g; cfg_y = y; cfg_c = c; cfg_w = w;
      end
   endfunction

   task automatic tick(input bit req, input bit hld, input bit load,
                       input int g, input int y, input int c, input int w);
      ped_req_i = req;
      hold_i = hld;
      cfg_load_i = load;
      green_time_i = TW'(g);
      yellow_time_i = TW'(y);
      clear_time_i = TW'(c);
      walk_time_i = TW'(w);
      @(posedge clk_i);
      model_edge(req, hld, load, g, y, c, w);
      #1;
      ped_req_i = 1'b0;
      hold_i = 1'b0;
      cfg_load_i = 1'b0;
   endtask

   task automatic do_reset();
      reset_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      reset_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      n_vec++;
      if (obs !== 13'b000_100_001_0_001) begin
         n_fail++;
         $display("FAIL reset_hold: got %b want %b", obs, 13'b000_100_001_0_001);
      end
      reset_ni = 1'b1;
      model_reset();
      n_vec++;
      if (obs !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_release: got %b want %b", obs, exp_vec());
      end
   endtask

   task automatic test_default_ring();
      int exp_seq[$];
      int lens[6] = '{6, 2, 1, 6, 2, 1};
      do_reset();
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < 6; p++)
            for (int k = 0; k < lens[p]; k++) exp_seq.push_back(p);
      for (int i = 0; i < 36; i++) begin
         if (i > 0) tick(0, 0, 0, 0, 0, 0, 0);
         n_vec++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL ring_model cyc %0d: got %b want %b", i, obs, exp_vec());
         end
         n_vec++;
         if (int'(phase_o) !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL ring_seq cyc %0d: phase %0d want %0d", i, phase_o, exp_seq[i]);
         end
         n_vec++;
         if ((ns_green_o && !ew_red_o) || (ew_green_o && !ns_red_o)) begin
            n_fail++;
            $display("FAIL green_safety cyc %0d: lamps %b want no conflict", i, obs[9:4]);
         end
      end
   endtask

   task automatic test_ped_pulse();
      int walk_cnt = 0;
      int ack_cnt = 0;
      int after = -1;
      bit seen = 0;
      do_reset();
      tick(0, 0, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 40 && after < 0; i++) begin
         n_vec++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL ped_pulse_model cyc %0d: got %b want %b", i, obs, exp_vec());
         end
         if (phase_o == 3'd6) begin
            seen = 1;
            walk_cnt++;
            if (!walk_o) begin
               n_fail++;
               $display("FAIL ped_pulse_walk_lamp: got 0 want 1");
            end
         end else if (seen) begin
            after = int'(phase_o);
         end
         if (ped_ack_o) ack_cnt++;
         if (after < 0) tick(0, 0, 0, 0, 0, 0, 0);
      end
      n_vec++;
      if (walk_cnt !== 4) begin
         n_fail++;
         $display("FAIL ped_pulse_walk_len: got %0d want 4", walk_cnt);
      end
      n_vec++;
      if (ack_cnt !== 1) begin
         n_fail++;
         $display("FAIL ped_pulse_ack_count: got %0d want 1", ack_cnt);
      end
      n_vec++;
      if (after !== 3 || ped_pending_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ped_pulse_exit: phase %0d pending %b want 3 and 0", after, ped_pending_o);
      end
   endtask

   task automatic test_ped_during_walk();
      int walk_cnt = 0;
      int walk_entries = 0;
      int exit_phase = -1;
      bit sent_b = 0;
      bit sent_w = 0;
      bit req;
      bit prev_walk = 0;
      do_reset();
      tick(0, 0, 1, 5, 1, 2, 3);
      for (int i = 0; i < 60; i++) begin
         req = 0;
         if (phase_o == 3'd5 && !sent_b) begin req = 1; sent_b = 1; end
         else if (phase_o == 3'd6 && !sent_w) begin req = 1; sent_w = 1; end
         tick(req, 0, 0, 0, 0, 0, 0);
         n_vec++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL ped_walk_model cyc %0d: got %b want %b", i, obs, exp_vec());
         end
         if (phase_o == 3'd6) begin
            walk_cnt++;
            if (!prev_walk) walk_entries++;
         end else if (prev_walk && exit_phase < 0) begin
            exit_phase = int'(phase_o);
         end
         prev_walk = (phase_o == 3'd6);
      end
      n_vec++;
      if (walk_cnt !== 4 || walk_entries !== 1) begin
         n_fail++;
         $display("FAIL ped_walk_single: %0d cycles in %0d walks want 4 in 1", walk_cnt,
                  walk_entries);
      end
      n_vec++;
      if (exit_phase !== 0) begin
         n_fail++;
         $display("FAIL ped_walk_exit: got %0d want 0", exit_phase);
      end
   endtask

   task automatic test_hold();
      int n3 = 0;
      int held = 0;
      bit hld;
      bit done = 0;
      do_reset();
      for (int i = 0; i < 60 && !done; i++) begin
         hld = (phase_o == 3'd3 && n3 >= 3 && held < 5);
         if (hld) held++;
         tick(0, hld, 0, 0, 0, 0, 0);
         n_vec++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL hold_model cyc %0d: got %b want %b", i, obs, exp_vec());
         end
         if (phase_o == 3'd3) n3++;
         else if (n3 > 0) done = 1;
      end
      n_vec++;
      if (n3 !== 11) begin
         n_fail++;
         $display("FAIL hold_ew_green_len: got %0d want 11", n3);
      end
   endtask

   task automatic test_cfg_load();
      int exp_seq[12] = '{0, 0, 0, 0, 0, 0, 1, 2, 2, 3, 3, 3};
      do_reset();
      for (int i = 0; i < 12; i++) begin
         n_vec++;
         if (int'(phase_o) !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL cfg_seq cyc %0d: phase %0d want %0d", i, phase_o, exp_seq[i]);
         end
         n_vec++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL cfg_model cyc %0d: got %b want %b", i, obs, exp_vec());
         end
         if (i == 0) tick(0, 0, 1, 2, 0, 1, 0);
         else tick(0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic test_reset_mid();
      int n0 = 0;
      bit found = 0;
      do_reset();
      tick(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20 && !found; i++) begin
         tick(0, 0, 0, 0, 0, 0, 0);
         if (phase_o == 3'd1) found = 1;
      end
      n_vec++;
      if (!found || ped_pending_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_setup: found %b pending %b want 1 and 1", found, ped_pending_o);
      end
      #1;
      reset_ni = 1'b0;
      #1;
      n_vec++;
      if (obs !== 13'b000_100_001_0_001) begin
         n_fail++;
         $display("FAIL reset_mid_async: got %b want %b", obs, 13'b000_100_001_0_001);
      end
      repeat (2) @(posedge clk_i);
      #1;
      reset_ni = 1'b1;
      model_reset();
      for (int i = 0; i < 10 && phase_o == 3'd0; i++) begin
         n0++;
         tick(0, 0, 0, 0, 0, 0, 0);
      end
      n_vec++;
      if (n0 !== 6) begin
         n_fail++;
         $display("FAIL reset_mid_restart: ns_green %0d cycles want 6", n0);
      end
   endtask

   task automatic test_random();
      bit req, hld, load;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         req = ($urandom_range(0, 9) == 0);
         hld = ($urandom_range(0, 9) == 0);
         load = ($urandom_range(0, 19) == 0);
         tick(req, hld, load, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 7));
         n_vec++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL random cyc %0d: got %b want %b", i, obs, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_ring();
      test_ped_pulse();
      test_ped_during_walk();
      test_hold();
      test_cfg_load();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
